// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int NUM_MASTERS_DEF = 3;
  localparam int MAX_HOLD_DEF    = 64;
  localparam int MAX_MASTERS     = 8;

  function automatic logic [MAX_MASTERS-1:0] onehot(input logic [2:0] idx);
    logic [MAX_MASTERS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping.
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS = NUM_MASTERS_DEF,
  parameter int ID_W        = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [ID_W-1:0]        rr_ptr,
  output logic [ID_W-1:0]        winner,
  output logic                   any_req
);

  // Scan from the far end down so the candidate closest to rr_ptr is written last.
  always_comb begin
    int idx;
    idx     = 0;
    winner  = '0;
    any_req = |req;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (req[idx]) winner = ID_W'(idx);
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin multi-master arbiter for the serial bus bridge.
// Optional hold-time limit is compiled in with `define ARB_TIMEOUT_EN.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS = NUM_MASTERS_DEF,
  parameter int MAX_HOLD    = MAX_HOLD_DEF,
  parameter int ID_W        = $clog2(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   done,
  output logic [NUM_MASTERS-1:0] grant,
  output logic                   grant_valid,
  output logic [ID_W-1:0]        grant_id,
  output logic                   bus_busy,
  output logic                   timeout,
  output logic [1:0]             arb_state
);

  // Handshake: a master holds req until it sees done (or gives up); grant is
  // held until done, owner withdrawal or forced release, then one RELEASE cycle.

  if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS || MAX_HOLD < 2) begin : g_bad_param
    $error("bus_arbiter: illegal NUM_MASTERS or MAX_HOLD");
  end

  arb_state_t      state, next_state;
  logic [ID_W-1:0] rr_ptr, winner, next_ptr;
  logic            any_req, exit_grant, force_rel;

  rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .ID_W        (ID_W)
  ) u_pick (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  assign next_ptr   = (grant_id == ID_W'(NUM_MASTERS - 1)) ? '0 : grant_id + 1'b1;
  assign exit_grant = (state == GRANT) && (done || !req[grant_id] || force_rel);

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(MAX_HOLD) > 8) ? $clog2(MAX_HOLD) : 8;

  logic [CNT_W-1:0] hold_cnt;
  logic             timeout_q;

  // A done or withdrawal on the limit cycle is an ordinary release.
  assign force_rel = (state == GRANT) && (hold_cnt == CNT_W'(MAX_HOLD - 1))
                     && !done && req[grant_id];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= force_rel;
      if (state == IDLE) hold_cnt <= '0;
      else if (state == GRANT) hold_cnt <= hold_cnt + 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign force_rel = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      grant_id <= '0;
      rr_ptr   <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && any_req) begin
        grant    <= NUM_MASTERS'(onehot(3'(winner)));
        grant_id <= winner;
      end else if (exit_grant) begin
        grant  <= '0;
        rr_ptr <= next_ptr;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req) next_state = GRANT;
      GRANT:   if (exit_grant) next_state = RELEASE;
      RELEASE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus_busy    = (state == GRANT) || (state == RELEASE);
    grant_valid = |grant;
    arb_state   = state;
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(grant));
      assert (grant_valid == (state == GRANT));
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (3 masters).
module tb_bus_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD = 8;
`else
  localparam int HOLD = 64;
`endif

  localparam logic [1:0] S_IDLE = 2'd0, S_GRANT = 2'd1, S_RELEASE = 2'd2;

  logic       clk, rst, done;
  logic [2:0] req, grant;
  logic       grant_valid, bus_busy, timeout;
  logic [1:0] grant_id, arb_state;

  int errors = 0;
  int checks = 0;
  logic [1:0] exp_q[$];

  bus_arbiter #(
    .NUM_MASTERS (3),
    .MAX_HOLD    (HOLD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .bus_busy    (bus_busy),
    .timeout     (timeout),
    .arb_state   (arb_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check("onehot0", 32'($onehot0(grant)), 32'd1);
  endtask

  task automatic check_out(input string tag, input logic [2:0] g, input logic [1:0] id,
                           input logic [1:0] st);
    check({tag, ".grant"}, 32'(grant), 32'(g));
    check({tag, ".grant_id"}, 32'(grant_id), 32'(id));
    check({tag, ".grant_valid"}, 32'(grant_valid), 32'(g != 3'b000));
    check({tag, ".state"}, 32'(arb_state), 32'(st));
    check({tag, ".bus_busy"}, 32'(bus_busy), 32'(st != S_IDLE));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] exp_id;
    int         held;
    int         tseen;

    rst  = 1'b1;
    req  = 3'b000;
    done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 3'b000, 2'd0, S_IDLE);
    check("reset.timeout", 32'(timeout), 32'd0);
    rst = 1'b0;

    // Single requester, grant latency, done, release, idle
    req = 3'b001;
    step(); check_out("t1.grant", 3'b001, 2'd0, S_GRANT);
    step(); step(); check_out("t1.hold", 3'b001, 2'd0, S_GRANT);
    done = 1'b1;
    step(); check_out("t1.release", 3'b000, 2'd0, S_RELEASE);
    done = 1'b0; req = 3'b000;
    step(); check_out("t1.idle", 3'b000, 2'd0, S_IDLE);

    // All request, round-robin 0,1,2,0 with two empty cycles between grants
    pulse_reset();
    exp_q = {2'd0, 2'd1, 2'd2, 2'd0};
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      exp_id = exp_q.pop_front();
      step(); check_out("t2.grant", 3'b001 << exp_id, exp_id, S_GRANT);
      done = 1'b1;
      step(); check_out("t2.release", 3'b000, exp_id, S_RELEASE);
      done = 1'b0;
      step(); check_out("t2.idle", 3'b000, exp_id, S_IDLE);
    end
    req = 3'b000;
    check("t2.queue_empty", 32'(exp_q.size()), 32'd0);

    // Owner withdrawal: pointer moves past the withdrawn owner (rr_ptr=1 now)
    req = 3'b011;
    step(); check_out("t3.grant1", 3'b010, 2'd1, S_GRANT);
    req = 3'b101;
    step(); check_out("t3.withdraw", 3'b000, 2'd1, S_RELEASE);
    step(); check_out("t3.idle", 3'b000, 2'd1, S_IDLE);
    step(); check_out("t3.grant2", 3'b100, 2'd2, S_GRANT);
    req = 3'b001;
    step(); check_out("t3.withdraw2", 3'b000, 2'd2, S_RELEASE);
    step(); check_out("t3.idle2", 3'b000, 2'd2, S_IDLE);
    step(); check_out("t3.grant0", 3'b001, 2'd0, S_GRANT);

    // done and withdrawal together, then done during RELEASE and IDLE
    done = 1'b1; req = 3'b000;
    step(); check_out("t4.release", 3'b000, 2'd0, S_RELEASE);
    step(); check_out("t4.done_in_release", 3'b000, 2'd0, S_IDLE);
    step(); check_out("t4.done_in_idle", 3'b000, 2'd0, S_IDLE);
    done = 1'b0;

    // Reset mid-grant: pointer sits at 2 before reset, back to 0 after
    req = 3'b010;
    step(); check_out("t5.grant1", 3'b010, 2'd1, S_GRANT);
    done = 1'b1; req = 3'b000;
    step(); check_out("t5.release", 3'b000, 2'd1, S_RELEASE);
    done = 1'b0;
    step();
    req = 3'b100;
    step(); check_out("t5.grant2", 3'b100, 2'd2, S_GRANT);
    #2;
    rst = 1'b1;
    #1;
    check_out("t5.async_reset", 3'b000, 2'd0, S_IDLE);
    check("t5.timeout", 32'(timeout), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = 3'b110;
    step(); check_out("t5.after_reset", 3'b010, 2'd1, S_GRANT);
    done = 1'b1; req = 3'b000;
    step();
    done = 1'b0;
    step(); check_out("t5.idle", 3'b000, 2'd1, S_IDLE);

    // Long hold by master 2 (rr_ptr=2)
    req = 3'b100;
    step(); check_out("t6.grant", 3'b100, 2'd2, S_GRANT);
`ifdef ARB_TIMEOUT_EN
    held = 1;
    tseen = 0;
    for (int c = 0; c < 7; c++) begin
      step();
      if (grant == 3'b100) held++;
      if (timeout) tseen++;
    end
    check("t6.held_cycles", 32'(held), 32'd8);
    check("t6.no_early_timeout", 32'(tseen), 32'd0);
    step(); check_out("t6.forced", 3'b000, 2'd2, S_RELEASE);
    check("t6.timeout_pulse", 32'(timeout), 32'd1);
    step(); check_out("t6.idle", 3'b000, 2'd2, S_IDLE);
    check("t6.timeout_end", 32'(timeout), 32'd0);
    step(); check_out("t6.regrant", 3'b100, 2'd2, S_GRANT);
`else
    held = 1;
    tseen = 0;
    for (int c = 0; c < 120; c++) begin
      step();
      if (grant == 3'b100 && arb_state == S_GRANT) held++;
      if (timeout) tseen++;
    end
    check("t6.held_cycles", 32'(held), 32'd121);
    check("t6.timeout_never", 32'(tseen), 32'd0);
`endif
    req = 3'b000;
    step(); check_out("t6.release", 3'b000, 2'd2, S_RELEASE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
